// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-master arbiter/sequencer for the single-port data memory,
//            with short locked bursts. Define DMEM_ARB_RR_EN for round-robin
//            tie-break from IDLE (default: master 0 wins ties).
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int RAM_SIZE  = 256,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_lock,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0]  c_idle      = 2'd0;
    localparam logic [1:0]  c_own0      = 2'd1;
    localparam logic [1:0]  c_own1      = 2'd2;
    localparam logic [31:0] c_ram_size  = 32'(RAM_SIZE);
    localparam logic [3:0]  c_max_burst = 4'(MAX_BURST);

    logic [1:0]  r_state;
    logic [3:0]  r_bcnt;
    logic        r_last;

    logic        w_own0;
    logic        w_own1;
    logic        w_req;
    logic        w_wr;
    logic        w_lock;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_err;
    logic        w_go;
    logic [31:0] w_rdata;
    logic [3:0]  w_bcnt_inc;
    logic        w_release;
    logic        w_other_req;
    logic        w_last_nxt;

    assign w_own0 = (r_state == c_own0);
    assign w_own1 = (r_state == c_own1);

    // The owner's request fields; everything reads as zero when nobody owns.
    always_comb begin
        w_req   = 1'b0;
        w_wr    = 1'b0;
        w_lock  = 1'b0;
        w_addr  = 32'h0;
        w_wdata = 32'h0;
        if (w_own0) begin
            w_req   = m0_req;
            w_wr    = m0_wr;
            w_lock  = m0_lock;
            w_addr  = m0_addr;
            w_wdata = m0_wdata;
        end else if (w_own1) begin
            w_req   = m1_req;
            w_wr    = m1_wr;
            w_lock  = m1_lock;
            w_addr  = m1_addr;
            w_wdata = m1_wdata;
        end
    end

    // Range check on the full 32-bit address so high bits cannot alias.
    assign w_err   = w_req && ((w_addr >= c_ram_size) || (w_addr[1:0] != 2'b00));
    assign w_go    = w_req && !w_err;
    assign w_rdata = w_go ? mem_rdata : 32'h0;

    assign mem_rd    = w_go && !w_wr;
    assign mem_wr    = w_go && w_wr;
    assign mem_addr  = w_req ? w_addr : 32'h0;
    assign mem_wdata = w_req ? w_wdata : 32'h0;

    assign m0_ack   = w_own0 && m0_req;
    assign m0_err   = w_own0 && w_err;
    assign m0_rdata = w_own0 ? w_rdata : 32'h0;
    assign m1_ack   = w_own1 && m1_req;
    assign m1_err   = w_own1 && w_err;
    assign m1_rdata = w_own1 ? w_rdata : 32'h0;

    // An idle cycle held under lock still counts toward the burst cap.
    assign w_bcnt_inc  = r_bcnt + 4'd1;
    assign w_release   = !w_lock || (w_bcnt_inc == c_max_burst);
    assign w_other_req = w_own0 ? m1_req : m0_req;
    assign w_last_nxt  = ((w_own0 || w_own1) && w_release) ? w_own1 : r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
            r_bcnt  <= 4'd0;
            r_last  <= 1'b1;
        end else begin
            r_last <= w_last_nxt;
            case (r_state)
                c_idle: begin
                    r_bcnt <= 4'd0;
                    if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
                        r_state <= r_last ? c_own0 : c_own1;
`else
                        r_state <= c_own0;
`endif
                    end else if (m0_req) begin
                        r_state <= c_own0;
                    end else if (m1_req) begin
                        r_state <= c_own1;
                    end
                end
                c_own0, c_own1: begin
                    if (w_release) begin
                        // Releasing master's own request is ignored at this edge.
                        r_bcnt <= 4'd0;
                        if (w_other_req) begin
                            r_state <= w_own0 ? c_own1 : c_own0;
                        end else begin
                            r_state <= c_idle;
                        end
                    end else begin
                        r_bcnt <= w_bcnt_inc;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_bcnt  <= 4'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
